coin_acceptor: RTL and testbench

- Front-end that drives the vending machine's coin inputs.
- Takes the raw coin-chute sensor level and synchronises and debounces it.
- Classifies each coin by how long the sensor stays high.
- Queues the classified coins and issues clean single-cycle coin100/coin150 pulses to the vending FSM, with at least one idle cycle between pulses.
- Invalid coins and coins that arrive when the queue is full are returned via a reject pulse.

---
 rtl/coin_acceptor.sv | 209 ++++++++++++++++++++
 tb/tb_coin_acceptor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin-chute front end: synchronise, debounce, classify by high width, queue, issue gapped pulses.
// Optional build macro COIN_ACCEPTOR_STATS_EN adds saturating pulse counters.
module coin_acceptor #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int WIDTH_W      = 8,
  parameter int W100_MIN     = 20,
  parameter int W100_MAX     = 30,
  parameter int W150_MIN     = 40,
  parameter int W150_MAX     = 50,
  parameter int QDEPTH       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coin_sense,
  input  logic        vend_busy,
  output logic        coin100,
  output logic        coin150,
  output logic        reject,
  output logic        jam,
  output logic        accept_inhibit
`ifdef COIN_ACCEPTOR_STATS_EN
  ,
  output logic [15:0] acc100_cnt,
  output logic [15:0] acc150_cnt,
  output logic [15:0] rej_cnt
`endif
);

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int PW  = $clog2(QDEPTH);
  localparam int CW  = PW + 1;

  localparam logic [DBW-1:0]     DB_ZERO = {DBW{1'b0}};
  localparam logic [DBW-1:0]     DB_ONE  = DBW'(1);
  localparam logic [DBW-1:0]     DB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [WIDTH_W-1:0] W_ZERO  = {WIDTH_W{1'b0}};
  localparam logic [WIDTH_W-1:0] W_ONE   = WIDTH_W'(1);
  localparam logic [WIDTH_W-1:0] W_MAX   = {WIDTH_W{1'b1}};
  localparam logic [WIDTH_W-1:0] W100_LO = WIDTH_W'(W100_MIN);
  localparam logic [WIDTH_W-1:0] W100_HI = WIDTH_W'(W100_MAX);
  localparam logic [WIDTH_W-1:0] W150_LO = WIDTH_W'(W150_MIN);
  localparam logic [WIDTH_W-1:0] W150_HI = WIDTH_W'(W150_MAX);
  localparam logic [CW-1:0]      C_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]      C_ONE   = CW'(1);
  localparam logic [CW-1:0]      C_FULL  = CW'(QDEPTH);
  localparam logic [CW-1:0]      C_INH   = CW'(QDEPTH - 1);
  localparam logic [PW-1:0]      P_ONE   = PW'(1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) begin
      sat_inc16 = v + 16'd1;
    end else begin
      sat_inc16 = v;
    end
  endfunction

  logic               s1_q, s1_d, s2_q, s2_d, deb_q, deb_d;
  logic [DBW-1:0]     stab_q, stab_d, low_q, low_d;
  logic               armed_q, armed_d;
  logic [WIDTH_W-1:0] width_q, width_d, width_inc_s;
  logic               jam_q, jam_d, gap_q, gap_d;
  logic [QDEPTH-1:0]  mem_q, mem_d;
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      count_q, count_d;
  logic               coin100_q, coin100_d, coin150_q, coin150_d;
  logic               reject_q, reject_d, inhibit_q, inhibit_d;
  logic               rise_s, fall_s, is100_s, is150_s, pop_s, push_s;
`ifdef COIN_ACCEPTOR_STATS_EN
  logic [15:0]        acc100_q, acc100_d, acc150_q, acc150_d, rej_q, rej_d;
`endif

  // Next-state logic for the whole datapath.
  always_comb begin
    s1_d = coin_sense;
    s2_d = s1_q;
    deb_d = deb_q;
    stab_d = DB_ZERO;
    if (s2_q != deb_q) begin
      if (stab_q == DB_LAST) begin
        deb_d = s2_q;
      end else begin
        stab_d = stab_q + DB_ONE;
      end
    end else begin
      stab_d = DB_ZERO;
    end
    rise_s = ~deb_q & deb_d;
    fall_s = deb_q & ~deb_d;

    // A coin already in the chute at reset release must see a clean low run before it counts.
    armed_d = armed_q | (~s2_q & (low_q == DB_LAST));
    if (s2_q) begin
      low_d = DB_ZERO;
    end else if (low_q == DB_LAST) begin
      low_d = low_q;
    end else begin
      low_d = low_q + DB_ONE;
    end

    width_inc_s = (width_q == W_MAX) ? W_MAX : (width_q + W_ONE);
    if (rise_s) begin
      width_d = W_ZERO;
    end else if (deb_q) begin
      width_d = width_inc_s;
    end else begin
      width_d = width_q;
    end
    jam_d = deb_d & (width_d == W_MAX);

    // width_inc_s counts the fall cycle itself, so it equals the number of debounced-high cycles.
    is100_s = (width_inc_s >= W100_LO) && (width_inc_s <= W100_HI) && (width_inc_s != W_MAX);
    is150_s = (width_inc_s >= W150_LO) && (width_inc_s <= W150_HI) && (width_inc_s != W_MAX);
    pop_s   = (count_q != C_ZERO) & ~vend_busy & ~gap_q;
    push_s  = fall_s & armed_q & (is100_s | is150_s) & ((count_q != C_FULL) | pop_s);

    reject_d  = fall_s & armed_q & ~push_s;
    gap_d     = pop_s;
    coin100_d = pop_s & ~mem_q[rd_q];
    coin150_d = pop_s & mem_q[rd_q];

    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_q] = is150_s;
      wr_d = wr_q + P_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + P_ONE;
    end else begin
      rd_d = rd_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase
    inhibit_d = (count_q >= C_INH);

`ifdef COIN_ACCEPTOR_STATS_EN
    acc100_d = sat_inc16(acc100_q, coin100_q);
    acc150_d = sat_inc16(acc150_q, coin150_q);
    rej_d    = sat_inc16(rej_q, reject_q);
`endif
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_q     <= 1'b0;
      stab_q    <= DB_ZERO;
      low_q     <= DB_ZERO;
      armed_q   <= 1'b0;
      width_q   <= W_ZERO;
      jam_q     <= 1'b0;
      gap_q     <= 1'b0;
      mem_q     <= {QDEPTH{1'b0}};
      wr_q      <= {PW{1'b0}};
      rd_q      <= {PW{1'b0}};
      count_q   <= C_ZERO;
      coin100_q <= 1'b0;
      coin150_q <= 1'b0;
      reject_q  <= 1'b0;
      inhibit_q <= 1'b0;
`ifdef COIN_ACCEPTOR_STATS_EN
      acc100_q  <= 16'h0000;
      acc150_q  <= 16'h0000;
      rej_q     <= 16'h0000;
`endif
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      deb_q     <= deb_d;
      stab_q    <= stab_d;
      low_q     <= low_d;
      armed_q   <= armed_d;
      width_q   <= width_d;
      jam_q     <= jam_d;
      gap_q     <= gap_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      coin100_q <= coin100_d;
      coin150_q <= coin150_d;
      reject_q  <= reject_d;
      inhibit_q <= inhibit_d;
`ifdef COIN_ACCEPTOR_STATS_EN
      acc100_q  <= acc100_d;
      acc150_q  <= acc150_d;
      rej_q     <= rej_d;
`endif
    end
  end

  assign coin100        = coin100_q;
  assign coin150        = coin150_q;
  assign reject         = reject_q;
  assign jam            = jam_q;
  assign accept_inhibit = inhibit_q;
`ifdef COIN_ACCEPTOR_STATS_EN
  assign acc100_cnt     = acc100_q;
  assign acc150_cnt     = acc150_q;
  assign rej_cnt        = rej_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: expected pulses are queued as coins are driven and
// matched against coin100/coin150/reject as they appear.
module tb_coin_acceptor;

  localparam logic [2:0] K_C100 = 3'b001;
  localparam logic [2:0] K_C150 = 3'b010;
  localparam logic [2:0] K_REJ  = 3'b100;
  localparam logic [2:0] K_NONE = 3'b000;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coin_sense = 1'b0;
  logic vend_busy = 1'b0;
  logic coin100, coin150, reject, jam, accept_inhibit;
`ifdef COIN_ACCEPTOR_STATS_EN
  logic [15:0] acc100_cnt, acc150_cnt, rej_cnt;
`endif

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_coin = -10;
  int   exp100 = 0, exp150 = 0, exprej = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [2:0] mon_obs;

  coin_acceptor dut (
    .clk            (clk),
    .reset          (reset),
    .coin_sense     (coin_sense),
    .vend_busy      (vend_busy),
    .coin100        (coin100),
    .coin150        (coin150),
    .reject         (reject),
    .jam            (jam),
    .accept_inhibit (accept_inhibit)
`ifdef COIN_ACCEPTOR_STATS_EN
    ,
    .acc100_cnt     (acc100_cnt),
    .acc150_cnt     (acc150_cnt),
    .rej_cnt        (rej_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
    if (kind == K_C100) exp100++;
    else if (kind == K_C150) exp150++;
    else exprej++;
  endtask

  // Drive a coin of n high cycles; optionally queue its expected result with exact timing.
  task automatic coin(input int n, input logic [2:0] kind, input bit timed, input int low_after);
    int k;
    @(negedge clk) coin_sense = 1'b1;
    repeat (n) @(negedge clk);
    coin_sense = 1'b0;
    k = cyc;
    if (kind != K_NONE) begin
      expect_pulse(kind, timed ? (k + ((kind == K_REJ) ? 6 : 7)) : -1);
    end
    repeat (low_after) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && (coin100 || coin150 || reject)) begin
      mon_obs = {reject, coin150, coin100};
      if (sb.size() == 0) begin
        check("unexpected", {29'd0, mon_obs}, {29'd0, K_NONE});
      end else begin
        mon_e = sb.pop_front();
        check("kind", {29'd0, mon_obs}, {29'd0, mon_e.kind});
        if (mon_e.cyc >= 0) check("latency", cyc, mon_e.cyc);
      end
      if (coin100 || coin150) begin
        check("gap", (cyc - last_coin) > 1, 1);
        last_coin = cyc;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_outs", {27'd0, coin100, coin150, reject, jam, accept_inhibit}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    coin(25, K_C100, 1'b1, 12);
    drain("t1_drain");
    check("t1_jam", jam, 0);

    coin(45, K_C150, 1'b1, 10);
    coin(22, K_C100, 1'b1, 12);
    drain("t2_drain");

    coin(35, K_REJ, 1'b1, 12);
    coin(10, K_REJ, 1'b1, 12);
    coin(60, K_REJ, 1'b1, 12);
    drain("t3_drain");

    coin(2, K_NONE, 1'b0, 20);
    drain("glitch");

    vend_busy = 1'b1;
    coin(25, K_NONE, 1'b0, 10);
    check("inh_1", accept_inhibit, 0);
    coin(25, K_NONE, 1'b0, 10);
    check("inh_2", accept_inhibit, 0);
    coin(25, K_NONE, 1'b0, 10);
    check("inh_3", accept_inhibit, 1);
    coin(25, K_NONE, 1'b0, 10);
    check("inh_4", accept_inhibit, 1);
    coin(25, K_REJ, 1'b1, 10);
    drain("busy_rej");
    for (int i = 0; i < 4; i++) expect_pulse(K_C100, -1);
    vend_busy = 1'b0;
    drain("busy_drain");
    check("inh_clr", accept_inhibit, 0);

    coin_sense = 1'b1;
    repeat (100) @(negedge clk);
    check("jam_early", jam, 0);
    repeat (190) @(negedge clk);
    check("jam_sat", jam, 1);
    repeat (10) @(negedge clk);
    coin_sense = 1'b0;
    expect_pulse(K_REJ, cyc + 6);
    repeat (8) @(negedge clk);
    check("jam_clr", jam, 0);
    drain("jam_drain");

`ifdef COIN_ACCEPTOR_STATS_EN
    check("st_100", acc100_cnt, exp100);
    check("st_150", acc150_cnt, exp150);
    check("st_rej", rej_cnt, exprej);
`endif

    // Reset with a coin in the chute; the coin must be ignored entirely.
    reset = 1'b1;
    coin_sense = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_outs", {27'd0, coin100, coin150, reject, jam, accept_inhibit}, 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    coin_sense = 1'b0;
    repeat (30) @(negedge clk);
    drain("held_drain");
`ifdef COIN_ACCEPTOR_STATS_EN
    check("st_rst", {acc100_cnt, rej_cnt}, 0);
`endif

    coin(25, K_C100, 1'b1, 12);
    drain("rearm_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
